// File: rtl/bsg_rolly_replay_pkg.sv
// Shared types and constants for the rolly FIFO replay controller.
package bsg_rolly_replay_pkg;

    // Read-side sequencer states
    typedef enum logic [1:0] {
        ST_SEND   = 2'd0,
        ST_REWIND = 2'd1,
        ST_HALT   = 2'd2
    } replay_state_e;

    // Bit positions inside the sticky err_o vector
    localparam int ERR_RETRY_BIT    = 0;
    localparam int ERR_SPURIOUS_BIT = 1;

endpackage : bsg_rolly_replay_pkg

// File: rtl/bsg_rolly_replay_timer.sv
// Idle counter for the replay controller: counts cycles spent waiting for a
// response while entries are outstanding and pulses timeout_o on the cycle
// the count reaches timeout_p-1. Only built when BSG_ROLLY_REPLAY_TIMEOUT_EN
// is defined.
module bsg_rolly_replay_timer
    import bsg_rolly_replay_pkg::*;
#(
    parameter int timeout_p = 64
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    output logic timeout_o
);

    localparam int cnt_w_lp = (timeout_p > 1) ? $clog2(timeout_p) : 1;
    localparam logic [cnt_w_lp-1:0] last_lp = cnt_w_lp'(timeout_p - 1);

    logic [cnt_w_lp-1:0] cnt_q, cnt_d;

    // A clear in the same cycle (e.g. an ACK) always beats the timeout.
    assign timeout_o = ~clr_i & (cnt_q == last_lp);

    // Next count: restart on clear or on firing, otherwise keep counting.
    always_comb begin
        // NOTE: every variable written here gets a value on every path, otherwise a latch is inferred.
        cnt_d = cnt_q + 1'b1;
        if (clr_i || timeout_o) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : bsg_rolly_replay_timer

// File: rtl/bsg_fifo_rolly_replay_ctrl.sv
// Read-side sequencer for a rolly FIFO feeding a lossy link. Streams FIFO
// entries to the link, tracks up to window_p unacknowledged entries, retires
// them on ACKs and replays them via rollback on NACK (or on timeout when
// BSG_ROLLY_REPLAY_TIMEOUT_EN is defined). Halts after max_retries_p
// consecutive replays without progress.
module bsg_fifo_rolly_replay_ctrl
    import bsg_rolly_replay_pkg::*;
#(
    parameter int width_p       = 8,
    parameter int lg_size_p     = 3,
    parameter int window_p      = 2 ** lg_size_p,
    parameter int timeout_p     = 64,
    parameter int max_retries_p = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 fifo_v_i,
    input  logic [width_p-1:0]   fifo_data_i,
    output logic                 fifo_yumi_o,
    output logic                 fifo_incr_v_o,
    output logic                 fifo_rollback_v_o,
    output logic                 fifo_ack_v_o,
    output logic                 link_v_o,
    output logic [width_p-1:0]   link_data_o,
    output logic [lg_size_p-1:0] link_seq_o,
    input  logic                 link_ready_i,
    input  logic                 resp_v_i,
    input  logic                 resp_nack_i,
    input  logic                 resp_all_i,
    input  logic                 halt_clr_i,
    output logic [1:0]           err_o,
    output logic [lg_size_p:0]   outstanding_o
);

    localparam int retry_w_lp = $clog2(max_retries_p + 1);
    localparam logic [lg_size_p:0]    window_lp    = (lg_size_p + 1)'(window_p);
    localparam logic [lg_size_p:0]    one_lp       = (lg_size_p + 1)'(1);
    localparam logic [retry_w_lp-1:0] max_retry_lp = retry_w_lp'(max_retries_p);

    replay_state_e          state_q, state_d;
    logic [lg_size_p:0]     outstanding_q, outstanding_d;
    logic [lg_size_p-1:0]   base_seq_q, base_seq_d;
    logic [retry_w_lp-1:0]  retry_q, retry_d;
    logic [1:0]             err_q, err_d;

    logic                   link_v, yumi, incr_v, ack_v, rollback_v;
    logic                   timeout;
    logic [lg_size_p:0]     yumi_ext;
    logic [retry_w_lp-1:0]  retry_inc;

    assign yumi_ext  = {{lg_size_p{1'b0}}, yumi};
    assign retry_inc = retry_q + 1'b1;

`ifdef BSG_ROLLY_REPLAY_TIMEOUT_EN
    logic timer_clr;

    // The timer only runs while SEND is waiting on outstanding entries.
    assign timer_clr = (state_q != ST_SEND) || (outstanding_q == '0) || resp_v_i;

    bsg_rolly_replay_timer #(
        .timeout_p (timeout_p)
    ) timer (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clr_i     (timer_clr),
        .timeout_o (timeout)
    );
`else
    logic unused_timeout_cfg;

    // Without the timer only a NACK can start a replay.
    assign timeout            = 1'b0;
    assign unused_timeout_cfg = (timeout_p == 0);
`endif

    // Next-state, counter updates and FIFO/link strobes. Each state drives at
    // most one of incr/ack/rollback, which keeps those strobes exclusive.
    always_comb begin
        state_d       = state_q;
        outstanding_d = outstanding_q;
        base_seq_d    = base_seq_q;
        retry_d       = retry_q;
        err_d         = err_q;
        link_v        = 1'b0;
        yumi          = 1'b0;
        incr_v        = 1'b0;
        ack_v         = 1'b0;
        rollback_v    = 1'b0;

        unique case (state_q)
            ST_SEND: begin
                link_v = fifo_v_i && (outstanding_q < window_lp);
                yumi   = link_v && link_ready_i;
                if (resp_v_i && (outstanding_q == '0)) begin
                    // Nothing in flight: the response cannot refer to anything.
                    err_d[ERR_SPURIOUS_BIT] = 1'b1;
                    outstanding_d = outstanding_q + yumi_ext;
                end else if (resp_v_i && resp_nack_i) begin
                    // Hold the FIFO still; REWIND rewinds to the checkpoint.
                    yumi    = 1'b0;
                    state_d = ST_REWIND;
                end else if (resp_v_i && resp_all_i) begin
                    ack_v         = 1'b1;
                    base_seq_d    = base_seq_q + outstanding_q[lg_size_p-1:0];
                    outstanding_d = yumi_ext;
                    retry_d       = '0;
                end else if (resp_v_i) begin
                    incr_v        = 1'b1;
                    base_seq_d    = base_seq_q + 1'b1;
                    outstanding_d = outstanding_q - one_lp + yumi_ext;
                    retry_d       = '0;
                end else if (timeout) begin
                    yumi    = 1'b0;
                    state_d = ST_REWIND;
                end else begin
                    outstanding_d = outstanding_q + yumi_ext;
                end
            end

            ST_REWIND: begin
                rollback_v    = 1'b1;
                outstanding_d = '0;
                retry_d       = retry_inc;
                if (retry_inc == max_retry_lp) begin
                    state_d               = ST_HALT;
                    err_d[ERR_RETRY_BIT]  = 1'b1;
                end else begin
                    state_d = ST_SEND;
                end
            end

            ST_HALT: begin
                if (halt_clr_i) begin
                    state_d = ST_SEND;
                    retry_d = '0;
                end
            end

            default: begin
                state_d = ST_SEND;
            end
        endcase
    end

    // State, counters and sticky error flags.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= ST_SEND;
            outstanding_q <= '0;
            base_seq_q    <= '0;
            retry_q       <= '0;
            err_q         <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            base_seq_q    <= base_seq_d;
            retry_q       <= retry_d;
            err_q         <= err_d;
        end
    end

    // Strobes are forced low while reset is held, since SEND (the reset state)
    // would otherwise pass fifo_v_i straight through.
    assign link_v_o          = link_v     & ~reset_i;
    assign fifo_yumi_o       = yumi       & ~reset_i;
    assign fifo_incr_v_o     = incr_v     & ~reset_i;
    assign fifo_ack_v_o      = ack_v      & ~reset_i;
    assign fifo_rollback_v_o = rollback_v & ~reset_i;
    assign link_data_o       = fifo_data_i;
    assign link_seq_o        = base_seq_q + outstanding_q[lg_size_p-1:0];
    assign err_o             = err_q;
    assign outstanding_o     = outstanding_q;

endmodule : bsg_fifo_rolly_replay_ctrl
